// File: rtl/spm_pkg.sv
// Shared types for the sparse-matrix row accumulator: default widths, FSM state and result record.
package spm_pkg;

  localparam int SPM_ELE_W_DEFAULT = 32;
  localparam int SPM_CNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [SPM_ELE_W_DEFAULT-1:0] row_id;
    logic [SPM_ELE_W_DEFAULT-1:0] sum;
    logic [SPM_CNT_W_DEFAULT-1:0] count;
  } spm_result_t;

endpackage

// File: rtl/spm_acc_adder.sv
// Row-sum adder: wraps modulo 2^W by default; with SPM_ACC_SAT_EN it clamps signed overflow.
// Purely combinational; the accumulator state lives in the top module.
module spm_acc_adder
  import spm_pkg::*;
#(
  parameter int W = SPM_ELE_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] raw;
  assign raw = a + b;

`ifdef SPM_ACC_SAT_EN
  // Overflow only when both operands share a sign that the raw result lost.
  always_comb begin
    sum = raw;
    if ((a[W-1] == b[W-1]) && (raw[W-1] != a[W-1])) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/spm_row_accumulator.sv
// Sums consecutive product beats sharing a row ID and emits one (row, sum, count) result per row.
// One-cycle result latency; a new row or flush stalls while an unaccepted result is pending.
module spm_row_accumulator
  import spm_pkg::*;
#(
  parameter int SPM_ELE_W = SPM_ELE_W_DEFAULT,
  parameter int CNT_W     = SPM_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SPM_ELE_W-1:0] in_row_id,
  input  logic [SPM_ELE_W-1:0] in_product,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SPM_ELE_W-1:0] out_row_id,
  output logic [SPM_ELE_W-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  acc_state_t           state_q, state_d;
  logic [SPM_ELE_W-1:0] acc_row_q, acc_row_d;
  logic [SPM_ELE_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                 out_vld_q, out_vld_d;
  logic [SPM_ELE_W-1:0] out_row_q, out_row_d;
  logic [SPM_ELE_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;

  logic                 slot_free;
  logic                 accept;
  logic                 row_hit;
  logic                 close_row;
  logic [SPM_ELE_W-1:0] add_sum;

  spm_acc_adder #(.W(SPM_ELE_W)) u_adder (
    .a  (acc_sum_q),
    .b  (in_product),
    .sum(add_sum)
  );

  // in_ready is forced low while reset is asserted so no beat is lost into a clearing register.
  assign slot_free = !out_vld_q || out_ready;
  assign in_ready  = slot_free && !flush && !rst_n;
  assign accept    = in_valid && in_ready;
  assign row_hit   = (state_q == ACC) && (in_row_id == acc_row_q);

  always_comb begin
    state_d   = state_q;
    acc_row_d = acc_row_q;
    acc_sum_d = acc_sum_q;
    acc_cnt_d = acc_cnt_q;
    out_vld_d = out_vld_q;
    out_row_d = out_row_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    close_row = 1'b0;

    if (out_ready) out_vld_d = 1'b0;

    if ((state_q == ACC) && flush && slot_free) begin
      close_row = 1'b1;
      state_d   = IDLE;
    end else if (accept) begin
      if (row_hit) begin
        acc_sum_d = add_sum;
        if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + CNT_ONE;
      end else begin
        close_row = (state_q == ACC);
        state_d   = ACC;
        acc_row_d = in_row_id;
        acc_sum_d = in_product;
        acc_cnt_d = CNT_ONE;
      end
    end

    // A closing event overrides the consume so a back-to-back result has no bubble.
    if (close_row) begin
      out_vld_d = 1'b1;
      out_row_d = acc_row_q;
      out_sum_d = acc_sum_q;
      out_cnt_d = acc_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      acc_row_q <= '0;
      acc_sum_q <= '0;
      acc_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_row_q <= '0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_row_q <= acc_row_d;
      acc_sum_q <= acc_sum_d;
      acc_cnt_q <= acc_cnt_d;
      out_vld_q <= out_vld_d;
      out_row_q <= out_row_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_row_id = out_row_q;
  assign out_sum    = out_sum_q;
  assign out_count  = out_cnt_q;
  assign busy       = (state_q == ACC);

endmodule

// File: tb/tb_spm_row_accumulator.sv
// Bench for spm_row_accumulator: directed row scenarios plus random beats/flushes against a row-list model.
// Define SPM_ACC_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_spm_row_accumulator;
  import spm_pkg::*;

  localparam int W = 32;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_row_id;
  logic [W-1:0] in_product;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_row_id;
  logic [W-1:0] out_sum;
  logic [C-1:0] out_count;
  logic         busy;

  always #5 clk = ~clk;

  spm_row_accumulator #(.SPM_ELE_W(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row_id (in_row_id),
    .in_product(in_product),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row_id(out_row_id),
    .out_sum   (out_sum),
    .out_count (out_count),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  spm_result_t exp_q[$];

  // Reference model: the currently open row as a plain record.
  bit           m_open = 1'b0;
  logic [W-1:0] m_row;
  logic [W-1:0] m_sum;
  int           m_cnt;
  bit           exp_vld_next = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPM_ACC_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  task automatic emit_open_row();
    spm_result_t r;
    r.row_id = m_row;
    r.sum    = m_sum;
    r.count  = C'(m_cnt);
    exp_q.push_back(r);
    exp_vld_next = 1'b1;
    m_open = 1'b0;
  endtask

  // One clock of stimulus; checks handshake signals and advances the model.
  task automatic cycle(input bit v, input logic [W-1:0] r, input logic [W-1:0] p,
                       input bit f, input bit ordy, output bit acc);
    bit slot;
    @(negedge clk);
    in_valid   = v;
    in_row_id  = r;
    in_product = p;
    flush      = f;
    out_ready  = ordy;
    #1;
    chk("busy", busy, m_open);
    if (exp_vld_next) chk("out_valid_latency", out_valid, 1);
    exp_vld_next = 1'b0;
    slot = !out_valid || out_ready;
    chk("in_ready", in_ready, slot && !f);
    acc = v && in_ready;
    if (f) begin
      if (m_open && slot) emit_open_row();
    end else if (acc) begin
      if (m_open && r == m_row) begin
        m_sum = ref_add(m_sum, p);
        if (m_cnt < 65535) m_cnt++;
      end else begin
        if (m_open) emit_open_row();
        m_open = 1'b1;
        m_row  = r;
        m_sum  = p;
        m_cnt  = 1;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] r, input logic [W-1:0] p, input bit ordy);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) cycle(1'b1, r, p, 1'b0, ordy, acc);
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycle(input bit f, input bit ordy);
    bit acc;
    cycle(1'b0, '0, '0, f, ordy, acc);
  endtask

  // Monitor: pops the scoreboard on each transfer and checks hold stability while stalled.
  bit           hold = 1'b0;
  logic [W-1:0] h_row, h_sum;
  logic [C-1:0] h_cnt;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_row", out_row_id, h_row);
          chk("hold_sum", out_sum, h_sum);
          chk("hold_count", out_count, h_cnt);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", out_valid, 0);
          end else begin
            spm_result_t e;
            e = exp_q.pop_front();
            chk("result_row", out_row_id, e.row_id);
            chk("result_sum", out_sum, e.sum);
            chk("result_count", out_count, e.count);
          end
          hold = 1'b0;
        end else if (out_valid) begin
          hold  = 1'b1;
          h_row = out_row_id;
          h_sum = out_sum;
          h_cnt = out_count;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    bit           acc;
    bit           pend = 1'b0;
    logic [W-1:0] pr, pp;

    rst_n      = 1'b1;
    in_valid   = 1'b1;
    in_row_id  = '0;
    in_product = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_row", out_row_id, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;

    // Single row of three beats.
    send(1, 3, 1); send(1, 3, 1); send(1, 3, 1);
    idle_cycle(1'b1, 1'b1);
    repeat (2) idle_cycle(1'b0, 1'b1);

    // Row change then flush.
    send(1, 2, 1); send(2, 5, 1); send(2, 5, 1);
    idle_cycle(1'b1, 1'b1);
    repeat (2) idle_cycle(1'b0, 1'b1);

    // Stalled result blocks a row-change beat until the consumer returns.
    send(8, 1, 0); send(9, 2, 0);
    repeat (3) cycle(1'b1, 10, 3, 1'b0, 1'b0, acc);
    send(10, 3, 1);
    idle_cycle(1'b1, 1'b1);
    repeat (2) idle_cycle(1'b0, 1'b1);

    // flush and in_valid together: beat held, then starts a new row.
    send(5, 4, 1);
    cycle(1'b1, 6, 7, 1'b1, 1'b1, acc);
    chk("flush_blocks_beat", acc, 0);
    send(6, 7, 1);
    idle_cycle(1'b1, 1'b1);
    repeat (2) idle_cycle(1'b0, 1'b1);

    // Signed overflow boundary.
    send(4, 32'h7FFF_FFFF, 1); send(4, 32'h0000_0001, 1);
    idle_cycle(1'b1, 1'b1);
    repeat (2) idle_cycle(1'b0, 1'b1);

    // Flush with nothing open must not emit.
    repeat (2) idle_cycle(1'b1, 1'b1);

    // Random beats, flushes and backpressure.
    for (int i = 0; i < 600; i++) begin
      bit f, ordy;
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pr   = W'($urandom_range(0, 3));
        pp   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFF0 + W'($urandom_range(0, 31)) : $urandom;
      end
      f    = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(pend, pr, pp, f, ordy, acc);
      if (acc) pend = 1'b0;
    end
    idle_cycle(1'b1, 1'b1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    // Reset mid-row discards the open row.
    send(7, 11, 1); send(7, 12, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    m_open       = 1'b0;
    exp_vld_next = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b0;
    idle_cycle(1'b1, 1'b1);
    repeat (3) begin
      idle_cycle(1'b0, 1'b1);
      chk("post_rst_no_output", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spm_row_accumulator.md
SPM_ROW_ACCUMULATOR -- requirements
Module: spm_row_accumulator

Interface
REQ-001 Parameter SPM_ELE_W, default 32, width of row IDs, products and sums.
REQ-002 Parameter CNT_W, default 16, width of the per-row product count.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  product beat valid from the channel multiplier.
REQ-006 in_ready  output  1  accumulator accepts the beat this cycle.
REQ-007 in_row_id  input  SPM_ELE_W  row ID of the beat (channel row_IDs_accumulator_out).
REQ-008 in_product  input  SPM_ELE_W  product value (channel mul_accumulator_out).
REQ-009 flush  input  1  end-of-stream request; closes the open row.
REQ-010 out_valid  output  1  completed row result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_row_id  output  SPM_ELE_W  row ID of the completed row.
REQ-013 out_sum  output  SPM_ELE_W  sum of all products of that row.
REQ-014 out_count  output  CNT_W  number of products summed.
REQ-015 busy  output  1  high while a row is open (state ACC).

Function
REQ-016 The block SHALL implement two states: IDLE (no open row) and ACC (open row held in acc_row, acc_sum, acc_cnt).
REQ-017 The block SHALL drive slot_free = !out_valid || out_ready, in_ready = slot_free && !flush.
REQ-018 A beat SHALL be accepted only when in_valid && in_ready.
REQ-019 In IDLE, an accepted beat SHALL load acc_row=in_row_id, acc_sum=in_product, acc_cnt=1 and move to ACC.
REQ-020 In ACC, an accepted beat with in_row_id==acc_row SHALL add in_product to acc_sum and increment acc_cnt, next cycle.
REQ-021 In ACC, an accepted beat with a different row ID SHALL load (acc_row, acc_sum, acc_cnt) into the output register and reopen the row with the new beat, staying in ACC.
REQ-022 flush in ACC with slot_free SHALL load the open row into the output register and move to IDLE; flush in IDLE SHALL be a no-op.
REQ-023 flush SHALL have priority over in_valid; a concurrent beat is not accepted and SHALL be held by the upstream.
REQ-024 out_valid SHALL rise the cycle after the closing event (one-cycle latency) and hold output fields stable until out_ready.
REQ-025 out_valid && out_ready with a simultaneous new closing event SHALL replace the result with no bubble cycle.
REQ-026 acc_sum SHALL wrap modulo 2^SPM_ELE_W (unless REQ-031); acc_cnt SHALL saturate at 2^CNT_W-1.
REQ-027 busy SHALL equal (state==ACC).

Reset
REQ-028 While rst_n is high, state SHALL be IDLE, out_valid=0, out_row_id=0, out_sum=0, out_count=0, busy=0, in_ready=0.
REQ-029 Reset mid-row SHALL discard the open row and any pending result with no output emitted.
REQ-030 After rst_n falls, in_ready SHALL follow REQ-017 from the first clock.

Configuration
REQ-031 With SPM_ACC_SAT_EN defined, signed two's-complement accumulation SHALL clamp to the most positive/negative SPM_ELE_W value on overflow; without it, addition SHALL wrap.

Structure
REQ-032 Package spm_pkg SHALL hold SPM_ELE_W default, the acc_state_t enum {IDLE, ACC} and the result struct (row_id, sum, count).
REQ-033 Sub-module spm_acc_adder SHALL hold the wrap/saturating adder selected by SPM_ACC_SAT_EN; all state stays in the top module.

Verification
REQ-034 Beats (row 1, 3),(1, 3),(1, 3) then flush, out_ready=1 -> one result row 1, sum 9, count 3, out_valid one cycle after flush.
REQ-035 Beats (1,2),(2,5),(2,5) then flush -> results (1,2,1) then (2,10,2), in order.
REQ-036 out_ready=0 with pending result, new row-change beat offered -> in_ready=0, result held stable; out_ready=1 -> next result follows without a gap.
REQ-037 flush and in_valid both high -> beat not accepted, open row emitted; beat accepted on the following cycle into a new row.
REQ-038 Beats row 4 products 0x7FFFFFFF and 1 -> sum 0x80000000 without SPM_ACC_SAT_EN, 0x7FFFFFFF with it.
REQ-039 rst_n pulsed high after two beats of row 7 -> out_valid stays 0, busy=0, next flush emits nothing.
